// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared definitions for the async-FIFO read-side drain block.
//   - rd_state_e : drain FSM state (IDLE, RUN, STOP, FLUSH), 2-bit encoding
//   - DATA_WIDTH_DEF / CNT_WIDTH_DEF : default widths for data and counters
package fifo_rd_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STOP  = 2'd2,
    FLUSH = 2'd3
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry output buffer between the FIFO pop port and the
// valid/ready stream.
//   rclk, rrst_n : clock, synchronous active-low reset
//   clr          : drop all buffered entries (wins over push/pop)
//   push, push_data : write at tail (caller guarantees cnt < 2)
//   m_ready      : downstream accept
//   m_data, m_valid : head entry / buffer non-empty
//   cnt          : occupancy 0..2
//   pop          : transfer happening this cycle (m_valid && m_ready)
module fifo_rd_skid #(
  parameter int DATA_WIDTH = fifo_rd_pkg::DATA_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic [1:0]            cnt,
  output logic                  pop
);

  logic [1:0][DATA_WIDTH-1:0] mem;
  logic                       wr_ptr;
  logic                       rd_ptr;

  assign m_valid = (cnt != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign pop     = m_valid && m_ready;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      // push+pop together leaves occupancy unchanged: 1 byte/cycle at cnt=1
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-clock-domain consumer for the async FIFO. Pops bytes via
// rinc/rdata/rempty and re-presents them on a valid/ready stream through a
// 2-entry buffer, with run/stop/flush control and a popped-byte counter.
//   rclk, rrst_n      : read clock, synchronous active-low reset
//   rempty, rdata     : FIFO status/data (rdata valid whenever rempty=0)
//   rinc              : FIFO pop strobe
//   rd_en             : 1 = consume, 0 = stop and drain the buffer
//   flush             : one-cycle pulse, discard buffer and empty the FIFO
//   m_data, m_valid, m_ready : output stream
//   rd_count          : entries popped since reset (wraps)
//   busy              : FSM not in IDLE
// Optional (FIFO_RD_STATS_EN defined):
//   stall_count : cycles in RUN starved (rempty=1 with buffer room)
//   bp_count    : cycles back-pressured (m_valid && !m_ready)
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
`ifdef FIFO_RD_STATS_EN
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  bp_count,
`endif
  output logic                  busy
);

  rd_state_e  state, state_nxt;
  logic [1:0] cnt;
  logic       pop;
  logic       push;
  logic       clr;
  logic       drained;

  // Only RUN writes the buffer; FLUSH pops are discarded.
  assign push = rinc && (state == RUN);
  // Entering FLUSH empties the buffer at the next edge.
  assign clr  = flush && (state != FLUSH);
  // Buffer will be empty after this cycle's transfer.
  assign drained = (cnt == 2'd0) || ((cnt == 2'd1) && pop);
  assign busy = (state != IDLE);

  fifo_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .clr       (clr),
    .push      (push),
    .push_data (rdata),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .cnt       (cnt),
    .pop       (pop)
  );

  always_ff @(posedge rclk) begin
    if (!rrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // rinc depends only on state, rempty and registered cnt, never on m_ready.
  always_comb begin
    state_nxt = state;
    rinc      = 1'b0;
    case (state)
      IDLE: begin
        if (flush)      state_nxt = FLUSH;
        else if (rd_en) state_nxt = RUN;
      end
      RUN: begin
        rinc = !rempty && (cnt < 2'd2);
        if (flush)       state_nxt = FLUSH;
        else if (!rd_en) state_nxt = STOP;
      end
      STOP: begin
        if (flush)        state_nxt = FLUSH;
        else if (rd_en)   state_nxt = RUN;
        else if (drained) state_nxt = IDLE;
      end
      FLUSH: begin
        rinc = !rempty;
        if (rempty) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n)   rd_count <= '0;
    else if (rinc) rd_count <= rd_count + CNT_WIDTH'(1);
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      stall_count <= '0;
      bp_count    <= '0;
    end else begin
      if ((state == RUN) && rempty && (cnt < 2'd2))
        stall_count <= stall_count + CNT_WIDTH'(1);
      if (m_valid && !m_ready)
        bp_count <= bp_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: directed bench for fifo_rd_drain with a queue-based
// FIFO model on the read port. Counter width is 4 to exercise wrap.
module tb_fifo_rd_drain;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] rd_count;
  logic          busy;
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] stall_count;
  logic [CW-1:0] bp_count;
`endif

  int errs = 0;
  int checks = 0;
  int npop = 0;
  logic last_rinc = 1'b0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] got[$];

  always #5 rclk = ~rclk;

  fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .rd_en    (rd_en),
    .flush    (flush),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .rd_count (rd_count),
`ifdef FIFO_RD_STATS_EN
    .stall_count (stall_count),
    .bp_count    (bp_count),
`endif
    .busy     (busy)
  );

  function automatic void upd();
    rempty = (q.size() == 0);
    rdata  = rempty ? '0 : q[0];
  endfunction

  // One rclk cycle: sample rinc/transfer just before the edge, update the
  // FIFO model just after it.
  task automatic step();
    logic r;
    #1;
    r = rinc;
    if (r && rempty) begin
      checks++; errs++;
      $display("FAIL underflow: rinc=1 while rempty=1");
    end
    if (m_valid && m_ready) got.push_back(m_data);
    @(posedge rclk);
    #1;
    if (r && q.size() > 0) begin
      void'(q.pop_front());
      npop++;
    end
    last_rinc = r;
    upd();
  endtask

  task automatic do_reset();
    rrst_n = 1'b0; rd_en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    q.delete(); got.delete(); upd();
    step();
    rrst_n = 1'b1;
    npop = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rinc !== 1'b0)    begin errs++; $display("FAIL reset_rinc: got %b want 0", rinc); end
    checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL reset_mvalid: got %b want 0", m_valid); end
    checks++; if (busy !== 1'b0)    begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rd_count !== 4'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", rd_count); end
    checks++; if (m_data !== 8'h00) begin errs++; $display("FAIL reset_mdata: got %h want 00", m_data); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back(8'h11 + 8'(i));
    upd();
    rd_en = 1'b1; m_ready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (!(last_rinc === 1'b1 && m_valid === 1'b1 && m_data === 8'h11 + 8'(i))) begin
        errs++;
        $display("FAIL stream_byte%0d: got rinc=%b v=%b d=%h want 1 1 %h",
                 i, last_rinc, m_valid, m_data, 8'h11 + 8'(i));
      end
    end
    step();
    checks++; if (rd_count !== 4'd8) begin errs++; $display("FAIL stream_count: got %0d want 8", rd_count); end
    checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL stream_end_valid: got %b want 0", m_valid); end
    rd_en = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) q.push_back(8'hA0 + 8'(i));
    upd();
    rd_en = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    checks++; if (npop !== 2)        begin errs++; $display("FAIL bp_pulses: got %0d want 2", npop); end
    checks++; if (m_data !== 8'hA0)  begin errs++; $display("FAIL bp_hold: got %h want a0", m_data); end
    checks++; if (m_valid !== 1'b1)  begin errs++; $display("FAIL bp_valid: got %b want 1", m_valid); end
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (got.size() != 4) begin
      errs++; $display("FAIL bp_xfer_count: got %0d want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (got[i] !== 8'hA0 + 8'(i)) begin
          errs++; $display("FAIL bp_order%0d: got %h want %h", i, got[i], 8'hA0 + 8'(i));
        end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_stop();
    do_reset();
    for (int i = 0; i < 5; i++) q.push_back(8'hB0 + 8'(i));
    upd();
    rd_en = 1'b1;
    step(); step(); step();
    rd_en = 1'b0; m_ready = 1'b1;
    npop = 0;
    step();
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL stop_busy: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (npop !== 0)     begin errs++; $display("FAIL stop_rinc: got %0d want 0", npop); end
    checks++; if (busy !== 1'b0)  begin errs++; $display("FAIL stop_idle: got %b want 0", busy); end
    checks++; if (q.size() != 3)  begin errs++; $display("FAIL stop_fifo_left: got %0d want 3", q.size()); end
    checks++;
    if (got.size() != 2 || got[0] !== 8'hB0 || got[1] !== 8'hB1) begin
      errs++; $display("FAIL stop_drain: got %0d bytes want b0 b1", got.size());
    end
  endtask

  task automatic test_flush();
    logic saw_valid;
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back(8'hC0 + 8'(i));
    upd();
    rd_en = 1'b1;
    step(); step(); step();
    rd_en = 1'b0; flush = 1'b1;
    npop = 0;
    step();
    flush = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL flush_mvalid: got %b want 0", m_valid); end
    saw_valid = 1'b0;
    for (int i = 0; i < 12 && busy; i++) begin
      step();
      if (m_valid) saw_valid = 1'b1;
    end
    checks++; if (npop !== 6)        begin errs++; $display("FAIL flush_pulses: got %0d want 6", npop); end
    checks++; if (rempty !== 1'b1)   begin errs++; $display("FAIL flush_empty: got %b want 1", rempty); end
    checks++; if (busy !== 1'b0)     begin errs++; $display("FAIL flush_idle: got %b want 0", busy); end
    checks++; if (rd_count !== 4'd8) begin errs++; $display("FAIL flush_count: got %0d want 8", rd_count); end
    checks++; if (saw_valid !== 1'b0) begin errs++; $display("FAIL flush_no_output: got %b want 0", saw_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back(8'h50 + 8'(i));
    upd();
    rd_en = 1'b1; m_ready = 1'b1;
    step(); step(); step();
    rrst_n = 1'b0;
    step();
    checks++; if (rinc !== 1'b0)     begin errs++; $display("FAIL rstmid_rinc: got %b want 0", rinc); end
    checks++; if (m_valid !== 1'b0)  begin errs++; $display("FAIL rstmid_mvalid: got %b want 0", m_valid); end
    checks++; if (rd_count !== 4'd0) begin errs++; $display("FAIL rstmid_count: got %0d want 0", rd_count); end
    checks++; if (busy !== 1'b0)     begin errs++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rrst_n = 1'b1; rd_en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) q.push_back(8'(i));
    upd();
    rd_en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    checks++; if (npop !== 17)       begin errs++; $display("FAIL wrap_pulses: got %0d want 17", npop); end
    checks++; if (rd_count !== 4'd1) begin errs++; $display("FAIL wrap_count: got %0d want 1", rd_count); end
    rd_en = 1'b0;
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    do_reset();
    rd_en = 1'b1; m_ready = 1'b1;
    step();
    step(); step(); step();
    checks++; if (stall_count !== 4'd3) begin errs++; $display("FAIL stats_stall: got %0d want 3", stall_count); end
    do_reset();
    q.push_back(8'hD0); upd();
    rd_en = 1'b1; m_ready = 1'b0;
    step(); step();
    for (int i = 0; i < 4; i++) step();
    checks++; if (bp_count !== 4'd4) begin errs++; $display("FAIL stats_bp: got %0d want 4", bp_count); end
    rd_en = 1'b0;
  endtask
`endif

  initial begin
    upd();
    test_reset();
    test_stream();
    test_backpressure();
    test_stop();
    test_flush();
    test_reset_mid();
    test_wrap();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
